// File: rtl/bp_cache_assoc.sv
// Set-associative cache with two combinational read ports and one write port.
// Fill order: tag hit, then lowest invalid way, then round-robin victim per set.
module bp_cache_assoc #(
   parameter int unsigned AWIDTH = 32,
   parameter int unsigned DWIDTH = 2,
   parameter int unsigned LINES  = 8,
   parameter int unsigned WAYS   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] ra0,
   output logic [DWIDTH-1:0] dout0,
   output logic              hit0,
   input  logic [AWIDTH-1:0] ra1,
   output logic [DWIDTH-1:0] dout1,
   output logic              hit1,
   input  logic [AWIDTH-1:0] wa,
   input  logic [DWIDTH-1:0] din,
   input  logic              we,
   input  logic              flush
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned WW = $clog2(WAYS);
   localparam int unsigned TW = AWIDTH - 2 - IW;

   logic [WAYS-1:0]   r_valid [LINES];
   logic [WW-1:0]     r_vict  [LINES];
   logic [TW-1:0]     r_tag   [LINES][WAYS];
   logic [DWIDTH-1:0] r_data  [LINES][WAYS];

   logic [IW-1:0] w_idx0, w_idx1, w_widx;
   logic [TW-1:0] w_tag0, w_tag1, w_wtag;
   logic          w_wmatch, w_has_inv;
   logic [WW-1:0] w_match_way, w_inv_way, w_way;
   logic          w_unused;

   assign w_idx0 = ra0[2 +: IW];
   assign w_idx1 = ra1[2 +: IW];
   assign w_widx = wa[2 +: IW];
   assign w_tag0 = ra0[AWIDTH-1 -: TW];
   assign w_tag1 = ra1[AWIDTH-1 -: TW];
   assign w_wtag = wa[AWIDTH-1 -: TW];

   // Word-aligned addressing: byte offset bits never take part in lookup.
   assign w_unused = ^{ra0[1:0], ra1[1:0], wa[1:0]};

   always_comb begin
      hit0  = 1'b0;
      dout0 = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (r_valid[w_idx0][w] && (r_tag[w_idx0][w] == w_tag0)) begin
            hit0  = 1'b1;
            dout0 = dout0 | r_data[w_idx0][w];
         end
      end
   end

   always_comb begin
      hit1  = 1'b0;
      dout1 = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (r_valid[w_idx1][w] && (r_tag[w_idx1][w] == w_tag1)) begin
            hit1  = 1'b1;
            dout1 = dout1 | r_data[w_idx1][w];
         end
      end
   end

   // Descending scan so the lowest-numbered invalid way wins.
   always_comb begin
      w_wmatch    = 1'b0;
      w_match_way = '0;
      w_has_inv   = 1'b0;
      w_inv_way   = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (r_valid[w_widx][w]) begin
            if (r_tag[w_widx][w] == w_wtag) begin
               w_wmatch    = 1'b1;
               w_match_way = WW'(w);
            end
         end else begin
            w_has_inv = 1'b1;
            w_inv_way = WW'(w);
         end
      end
   end

   assign w_way = w_wmatch ? w_match_way : (w_has_inv ? w_inv_way : r_vict[w_widx]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < int'(LINES); l++) begin
            r_valid[l] <= '0;
            r_vict[l]  <= '0;
         end
      end else if (flush) begin
         for (int l = 0; l < int'(LINES); l++) begin
            r_valid[l] <= '0;
            r_vict[l]  <= '0;
         end
      end else if (we) begin
         r_valid[w_widx][w_way] <= 1'b1;
         if (!w_wmatch && !w_has_inv) begin
            r_vict[w_widx] <= r_vict[w_widx] + WW'(1);
         end
      end
   end

   // Tag/data survive reset and flush; only valid bits qualify a hit.
   always_ff @(posedge clk) begin
      if (!reset && !flush && we) begin
         r_tag[w_widx][w_way]  <= w_wtag;
         r_data[w_widx][w_way] <= din;
      end
   end

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Self-checking bench for bp_cache_assoc (LINES=8, WAYS=2, DWIDTH=2).
// Vectors carry expected read results; a scoreboard queue pairs them with sampled outputs.
module tb_bp_cache_assoc;

   logic        clk;
   logic        reset;
   logic [31:0] ra0, ra1, wa;
   logic [1:0]  dout0, dout1, din;
   logic        hit0, hit1, we, flush;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic        flush;
      logic [31:0] wa;
      logic [1:0]  din;
      logic [31:0] ra0;
      logic [31:0] ra1;
      logic        eh0;
      logic [1:0]  ed0;
      logic        eh1;
      logic [1:0]  ed1;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   bp_cache_assoc #(
      .AWIDTH (32),
      .DWIDTH (2),
      .LINES  (8),
      .WAYS   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ra0   (ra0),
      .dout0 (dout0),
      .hit0  (hit0),
      .ra1   (ra1),
      .dout1 (dout1),
      .hit1  (hit1),
      .wa    (wa),
      .din   (din),
      .we    (we),
      .flush (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic w, input logic f, input logic [31:0] a,
                               input logic [1:0] d, input logic [31:0] r0, input logic [31:0] r1,
                               input logic h0, input logic [1:0] d0, input logic h1,
                               input logic [1:0] d1);
      vec_t v;
      v.we = w; v.flush = f; v.wa = a; v.din = d; v.ra0 = r0; v.ra1 = r1;
      v.eh0 = h0; v.ed0 = d0; v.eh1 = h1; v.ed1 = d1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Entered just after a rising edge; samples mid-period, then steps one cycle.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      we = v.we; flush = v.flush; wa = v.wa; din = v.din; ra0 = v.ra0; ra1 = v.ra1;
      sb.push_back(v);
      #2;
      e = sb.pop_front();
      check({tag, " hit0"},  {31'd0, hit0}, {31'd0, e.eh0});
      check({tag, " dout0"}, {30'd0, dout0}, {30'd0, e.ed0});
      check({tag, " hit1"},  {31'd0, hit1}, {31'd0, e.eh1});
      check({tag, " dout1"}, {30'd0, dout1}, {30'd0, e.ed1});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; we = 1'b1; flush = 1'b0; wa = 32'h08; din = 2'd3;
      ra0 = 32'h08; ra1 = 32'h28;

      // Table: set 2 holds tags 0x08/0x28/0x48/0x68; 0x0C is set 3; 0x10 is set 4.
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h08, 3, 32'h08, 32'h1008, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h1008, 1, 3, 0, 0));
      vecs.push_back(mk(1, 0, 32'h28, 1, 32'h08, 32'h28, 1, 3, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 1, 3, 1, 1));
      vecs.push_back(mk(1, 0, 32'h08, 1, 32'h08, 32'h28, 1, 3, 1, 1));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 1, 1, 1, 1));
      vecs.push_back(mk(1, 0, 32'h48, 2, 32'h48, 32'h08, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h48, 32'h28, 1, 2, 1, 1));
      vecs.push_back(mk(1, 0, 32'h68, 0, 32'h68, 32'h48, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h28, 32'h48, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h68, 32'h48, 1, 0, 1, 2));
      vecs.push_back(mk(1, 0, 32'h08, 3, 32'h68, 32'h48, 1, 0, 1, 2));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h08, 32'h48, 1, 3, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h68, 32'h48, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0C, 2, 32'h0C, 32'h08, 0, 0, 1, 3));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h0C, 32'h0F, 1, 2, 1, 2));
      vecs.push_back(mk(1, 1, 32'h10, 3, 32'h08, 32'h10, 1, 3, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h10, 32'h08, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h68, 32'h0C, 0, 0, 0, 0));
      // Refill set 2 so its victim pointer ends at 1 before the mid-period reset.
      vecs.push_back(mk(1, 0, 32'h08, 2, 32'h08, 32'h28, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h28, 1, 32'h08, 32'h28, 1, 2, 0, 0));
      vecs.push_back(mk(1, 0, 32'h48, 3, 32'h08, 32'h28, 1, 2, 1, 1));
      vecs.push_back(mk(0, 0, 32'h00, 0, 32'h48, 32'h28, 1, 3, 1, 1));

      // Reset held across an edge with we=1: outputs idle, write dropped.
      #3;
      check("rst hit0",  {31'd0, hit0}, 32'd0);
      check("rst dout0", {30'd0, dout0}, 32'd0);
      check("rst hit1",  {31'd0, hit1}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 0, 0, 0, 0), "post_rst");

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Mid-period async reset with 0x48 and 0x28 valid.
      #2;
      reset = 1'b1; we = 1'b1; wa = 32'h68; din = 2'd1;
      #1;
      check("midrst hit0",  {31'd0, hit0}, 32'd0);
      check("midrst hit1",  {31'd0, hit1}, 32'd0);
      check("midrst dout0", {30'd0, dout0}, 32'd0);
      check("midrst dout1", {30'd0, dout1}, 32'd0);
      @(posedge clk);
      #1;
      ra0 = 32'h68;
      #1;
      check("midrst held hit0", {31'd0, hit0}, 32'd0);
      reset = 1'b0; we = 1'b0;
      apply(mk(0, 0, 32'h00, 0, 32'h68, 32'h48, 0, 0, 0, 0), "r0");
      apply(mk(1, 0, 32'h08, 2, 32'h08, 32'h28, 0, 0, 0, 0), "r1");
      apply(mk(1, 0, 32'h28, 1, 32'h08, 32'h28, 1, 2, 0, 0), "r2");
      apply(mk(1, 0, 32'h48, 3, 32'h08, 32'h28, 1, 2, 1, 1), "r3");
      apply(mk(0, 0, 32'h00, 0, 32'h08, 32'h28, 0, 0, 1, 1), "r4");
      apply(mk(0, 0, 32'h00, 0, 32'h48, 32'h68, 1, 3, 0, 0), "r5");

      check("sb drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_cache_assoc.md
BP_CACHE_ASSOC -- requirements
Module: bp_cache_assoc

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 2, data width per entry in bits.
REQ-003 SHALL have parameter LINES, default 8, number of sets; power of two, >=2.
REQ-004 SHALL have parameter WAYS, default 2, ways per set; power of two, >=2.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port ra0  in  AWIDTH  read address, port 0.
REQ-008 SHALL have port dout0  out  DWIDTH  read data, port 0.
REQ-009 SHALL have port hit0  out  1  port-0 tag match in a valid way.
REQ-010 SHALL have port ra1  in  AWIDTH  read address, port 1.
REQ-011 SHALL have port dout1  out  DWIDTH  read data, port 1.
REQ-012 SHALL have port hit1  out  1  port-1 tag match in a valid way.
REQ-013 SHALL have port wa  in  AWIDTH  write address.
REQ-014 SHALL have port din  in  DWIDTH  write data.
REQ-015 SHALL have port we  in  1  write enable.
REQ-016 SHALL have port flush  in  1  synchronous invalidate-all.

Function
REQ-017 SHALL ignore address bits [1:0]; index = addr[2 +: log2(LINES)]; tag = addr[AWIDTH-1 : 2+log2(LINES)].
REQ-018 SHALL hold per way: valid bit, tag, DWIDTH data; per set: victim pointer, log2(WAYS) bits.
REQ-019 SHALL compute hitN/doutN combinationally from raN and current state, zero cycles latency; both ports independent, same address allowed.
REQ-020 SHALL drive doutN = 0 when hitN = 0; on hit, doutN = data of the matching valid way.
REQ-021 SHALL NOT bypass write data: a read of wa in the cycle of the write returns pre-edge contents; new data visible from the cycle after the edge.
REQ-022 SHALL, on we=1 with wa tag matching a valid way in its set, overwrite that way's data only; victim pointer unchanged.
REQ-023 SHALL, on we=1 with no match and an invalid way present, allocate the lowest-numbered invalid way (set valid, tag, data); victim pointer unchanged.
REQ-024 SHALL, on we=1 with no match and all ways valid, replace the way selected by the victim pointer, then increment pointer modulo WAYS (wraps WAYS-1 -> 0).
REQ-025 SHALL guarantee at most one valid way per set holds a given tag.
REQ-026 SHALL, on flush=1, clear all valid bits and victim pointers at the edge; flush has priority over we (simultaneous write dropped).
REQ-027 SHALL leave tag/data storage unchanged on flush; only valid bits determine hits.

Reset
REQ-028 SHALL, on reset assertion, immediately clear all valid bits and victim pointers, independent of clk.
REQ-029 SHALL hold hit0=hit1=0 and dout0=dout1=0 during and after reset until a write occurs.
REQ-030 SHALL ignore we and flush while reset=1; first write accepted on first rising edge after deassertion.

Verification (LINES=8, WAYS=2, DWIDTH=2; 0x08, 0x28, 0x48, 0x68 all map to set 2)
REQ-031 SHALL cover: reset, ra0=0x08 -> hit0=0, dout0=0; write 0x08=2'b11 -> next cycle hit0=1, dout0=2'b11; in write cycle hit0 still 0.
REQ-032 SHALL cover: write 0x08=3, then 0x28=1 -> ra0=0x08 hit 3, ra1=0x28 hit 1 simultaneously; rewrite 0x08=2'b01 -> dout0=2'b01, 0x28 still hit.
REQ-033 SHALL cover: after above, write 0x48=2 -> 0x08 miss, 0x28 hit, 0x48 hit; write 0x68=0 -> 0x28 miss, 0x48 and 0x68 hit (pointer wrap).
REQ-034 SHALL cover: flush=1 and we=1 (wa=0x10) same cycle -> all reads miss next cycle, including 0x10.
REQ-035 SHALL cover: reset asserted mid-clock-period with entries valid -> hit0/hit1 drop to 0 before next edge; subsequent fill uses way 0 then way 1.
